// File: rtl/router_pkg.sv
`default_nettype none
// router_pkg: shared widths, transmitter state encoding and header helpers for the router source side.
// Rev 1.0
package router_pkg;

  localparam int DATA_W   = 8;
  localparam int LEN_W    = 6;
  localparam int ADDR_W   = 2;
  localparam int NUM_DEST = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_PARITY  = 2'd3
  } tx_state_t;

  function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

  function automatic logic dest_legal(input logic [ADDR_W-1:0] addr);
    return int'(addr) < NUM_DEST;
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_parity_gen.sv
`default_nettype none
// router_parity_gen: running XOR over the bytes of one packet; load seeds it with the header.
// Rev 1.0
module router_parity_gen
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] parity
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      parity <= '0;
    end else if (load) begin
      parity <= din;
    end else if (en) begin
      parity <= parity ^ din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// router_pkt_tx: drives header, payload and parity bytes into the router input port, stalling on busy.
// Rev 1.0
module router_pkt_tx
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  pay_len,
  output logic              req_ready,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic              busy,
  input  logic              abort,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              tx_done,
  output logic              err_req,
  output logic              err_underrun
);

  tx_state_t         state, state_d;
  logic [LEN_W-1:0]  cnt, cnt_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d;
  logic              tx_done_d;
  logic              err_req_d;
  logic              underrun_d;
  logic              par_load;
  logic              par_en;
  logic [DATA_W-1:0] par_din;
  logic [DATA_W-1:0] parity;
  logic [DATA_W-1:0] hdr;
  logic [DATA_W-1:0] pay_byte;
  logic              req_legal;

  assign hdr       = make_header(pay_len, dest_addr);
  assign req_legal = dest_legal(dest_addr) && (pay_len != '0);
  assign req_ready = (state == ST_IDLE) && !busy;
  assign pl_ready  = ((state == ST_HEADER) || ((state == ST_PAYLOAD) && (cnt != '0))) && !busy;
  // A missing payload byte is replaced by zero so the packet length never changes.
  assign pay_byte  = pl_valid ? pl_data : '0;

  router_parity_gen u_parity (
    .clk    (clk),
    .resetn (resetn),
    .load   (par_load),
    .en     (par_en),
    .din    (par_din),
    .parity (parity)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    data_d     = data_out;
    valid_d    = pkt_valid;
    tx_done_d  = 1'b0;
    err_req_d  = 1'b0;
    underrun_d = err_underrun;
    par_load   = 1'b0;
    par_en     = 1'b0;
    par_din    = pay_byte;

    if (abort) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      data_d  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && req_ready) begin
            if (req_legal) begin
              state_d    = ST_HEADER;
              data_d     = hdr;
              valid_d    = 1'b1;
              cnt_d      = pay_len;
              par_load   = 1'b1;
              par_din    = hdr;
              underrun_d = 1'b0;
            end else begin
              err_req_d = 1'b1;
            end
          end
        end
        ST_HEADER: begin
          if (!busy) begin
            state_d = ST_PAYLOAD;
            data_d  = pay_byte;
            par_en  = 1'b1;
            cnt_d   = cnt - LEN_W'(1);
          end
        end
        ST_PAYLOAD: begin
          if (!busy) begin
            if (cnt != '0) begin
              data_d = pay_byte;
              par_en = 1'b1;
              cnt_d  = cnt - LEN_W'(1);
            end else begin
              state_d = ST_PARITY;
              data_d  = parity;
              valid_d = 1'b0;
            end
          end
        end
        ST_PARITY: begin
          if (!busy) begin
            state_d   = ST_IDLE;
            data_d    = '0;
            tx_done_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (pl_ready && !pl_valid) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt          <= '0;
      data_out     <= '0;
      pkt_valid    <= 1'b0;
      tx_done      <= 1'b0;
      err_req      <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      cnt          <= cnt_d;
      data_out     <= data_d;
      pkt_valid    <= valid_d;
      tx_done      <= tx_done_d;
      err_req      <= err_req_d;
      err_underrun <= underrun_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// tb_router_pkt_tx: request-table vectors, directed corner sequences and randomized packets vs a byte-sequence model.
// Rev 1.0
module tb_router_pkt_tx;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] pay_len;
  logic       req_ready;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic       abort;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_done;
  logic       err_req;
  logic       err_underrun;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] pay_q[$];
  bit         inval_q[$];
  bit         busy_q[$];
  logic [7:0] last_hdr;
  logic [7:0] last_par;

  typedef struct {
    logic [1:0] d;
    logic [5:0] l;
    bit         want_err;
    logic [7:0] want_hdr;
  } req_vec_t;

  req_vec_t vec[6];

  router_pkt_tx dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .dest_addr    (dest_addr),
    .pay_len      (pay_len),
    .req_ready    (req_ready),
    .pl_data      (pl_data),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .busy         (busy),
    .abort        (abort),
    .pkt_valid    (pkt_valid),
    .data_out     (data_out),
    .tx_done      (tx_done),
    .err_req      (err_req),
    .err_underrun (err_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
  endtask

  // Sends one packet using pay_q/inval_q/busy_q; expectations come from the byte-position model.
  task automatic run_pkt(input logic [1:0] d, input logic [5:0] l, input bit rnd_busy);
    logic [7:0] exp_b[$];
    logic [7:0] par;
    int         k;
    int         guard;
    bit         ub;
    bit         b;
    exp_b = {};
    par   = {l, d};
    exp_b.push_back(par);
    for (int i = 0; i < int'(l); i++) begin
      logic [7:0] v;
      v = inval_q[i] ? 8'h00 : pay_q[i];
      exp_b.push_back(v);
      par ^= v;
    end
    exp_b.push_back(par);

    @(negedge clk);
    start = 1'b1; dest_addr = d; pay_len = l; busy = 1'b0; abort = 1'b0; pl_valid = 1'b0;
    #1 chk("req_ready_at_start", req_ready, 1);
    @(negedge clk);
    start = 1'b0;
    k = 0; ub = 1'b0; guard = 0;
    while (k <= int'(l) + 1 && guard < 2000) begin
      if (busy_q.size() > 0) b = busy_q.pop_front();
      else b = rnd_busy ? ($urandom_range(3) == 0) : 1'b0;
      busy     = b;
      pl_data  = (k < int'(l)) ? pay_q[k] : 8'($urandom);
      pl_valid = (k < int'(l)) ? !inval_q[k] : 1'($urandom_range(1));
      #1;
      chk("pkt_valid", pkt_valid, (k <= int'(l)));
      chk("data_out", data_out, exp_b[k]);
      chk("pl_ready", pl_ready, (!b && k < int'(l)));
      chk("err_underrun", err_underrun, ub);
      chk("tx_done_early", tx_done, 0);
      if (k == 0) last_hdr = data_out;
      if (k == int'(l) + 1) last_par = data_out;
      if (!b) begin
        if (k < int'(l) && inval_q[k]) ub = 1'b1;
        k++;
      end
      guard++;
      @(negedge clk);
    end
    chk("pkt_timeout", (guard < 2000), 1);
    busy = 1'b0; pl_valid = 1'b0;
    #1;
    chk("tx_done", tx_done, 1);
    chk("pkt_valid_after", pkt_valid, 0);
    chk("data_out_after", data_out, 0);
    chk("err_underrun_after", err_underrun, ub);
    chk("req_ready_after", req_ready, 1);
    @(negedge clk);
    #1 chk("tx_done_pulse", tx_done, 0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; dest_addr = '0; pay_len = '0; pl_data = '0;
    pl_valid = 1'b0; busy = 1'b0; abort = 1'b0;
    last_hdr = '0; last_par = '0;
    #12;
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_err_req", err_req, 0);
    chk("rst_err_underrun", err_underrun, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_pl_ready", pl_ready, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Request table: illegal requests pulse err_req, legal ones show the header then get aborted.
    vec[0] = '{2'd3, 6'd4,  1'b1, 8'h00};
    vec[1] = '{2'd0, 6'd0,  1'b1, 8'h00};
    vec[2] = '{2'd3, 6'd0,  1'b1, 8'h00};
    vec[3] = '{2'd0, 6'd63, 1'b0, 8'hFC};
    vec[4] = '{2'd2, 6'd1,  1'b0, 8'h06};
    vec[5] = '{2'd1, 6'd5,  1'b0, 8'h15};
    foreach (vec[i]) begin
      @(negedge clk);
      start = 1'b1; dest_addr = vec[i].d; pay_len = vec[i].l; busy = 1'b0;
      #1 chk("vec_req_ready", req_ready, 1);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("vec_err_req", err_req, vec[i].want_err);
      chk("vec_pkt_valid", pkt_valid, !vec[i].want_err);
      chk("vec_data_out", data_out, vec[i].want_hdr);
      chk("vec_req_ready_after", req_ready, vec[i].want_err);
      if (!vec[i].want_err) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("vec_abort_valid", pkt_valid, 0);
        chk("vec_abort_data", data_out, 0);
      end
      @(negedge clk);
      #1 chk("vec_err_req_pulse", err_req, 0);
    end

    // Reference packet with no stalls.
    pay_q = '{8'hA5, 8'h3C, 8'h0F}; inval_q = '{0, 0, 0}; busy_q = {};
    run_pkt(2'd1, 6'd3, 1'b0);
    chk("t1_header", last_hdr, 8'h0D);
    chk("t1_parity", last_par, 8'h9B);

    // Same packet, two busy cycles while the second payload byte is on the bus.
    busy_q = '{0, 0, 1, 1, 0, 0, 0};
    run_pkt(2'd1, 6'd3, 1'b0);
    chk("t2_parity", last_par, 8'h9B);

    // Underrun on the second byte: zero inserted, flag sticky until the next accepted start.
    pay_q = '{8'h11, 8'h77}; inval_q = '{0, 1}; busy_q = {};
    run_pkt(2'd2, 6'd2, 1'b0);
    chk("t4_parity", last_par, 8'h1B);
    chk("t4_underrun_sticky", err_underrun, 1);
    pay_q = '{8'h42}; inval_q = '{0};
    run_pkt(2'd0, 6'd1, 1'b0);

    // Abort in PAYLOAD while busy.
    @(negedge clk);
    start = 1'b1; dest_addr = 2'd1; pay_len = 6'd3; busy = 1'b0;
    @(negedge clk);
    start = 1'b0; pl_data = 8'hA5; pl_valid = 1'b1;
    @(negedge clk);
    busy = 1'b1; abort = 1'b1;
    #1 chk("t5_payload_byte", data_out, 8'hA5);
    @(negedge clk);
    busy = 1'b0; abort = 1'b0; pl_valid = 1'b0;
    #1;
    chk("t5_pkt_valid", pkt_valid, 0);
    chk("t5_data_out", data_out, 0);
    chk("t5_req_ready", req_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("t5_no_tx_done", tx_done, 0);
      chk("t5_idle_valid", pkt_valid, 0);
    end

    // Asynchronous reset in the middle of the payload.
    @(negedge clk);
    start = 1'b1; dest_addr = 2'd2; pay_len = 6'd4; busy = 1'b0;
    @(negedge clk);
    start = 1'b0; pl_data = 8'h5A; pl_valid = 1'b1;
    @(negedge clk);
    #1 chk("t6_mid_valid", pkt_valid, 1);
    #1 resetn = 1'b0;
    #1;
    chk("t6_rst_valid", pkt_valid, 0);
    chk("t6_rst_data", data_out, 0);
    chk("t6_rst_underrun", err_underrun, 0);
    @(negedge clk);
    resetn = 1'b1; pl_valid = 1'b0;
    pay_q = '{8'hC3}; inval_q = '{0}; busy_q = {};
    run_pkt(2'd2, 6'd1, 1'b0);
    chk("t6_parity", last_par, 8'hC3 ^ 8'h06);

    // Randomized packets with random stalls and occasional underruns.
    for (int p = 0; p < 25; p++) begin
      logic [1:0] d;
      logic [5:0] l;
      d = 2'($urandom_range(2));
      l = (p == 7) ? 6'd63 : 6'($urandom_range(12, 1));
      pay_q = {}; inval_q = {}; busy_q = {};
      for (int i = 0; i < int'(l); i++) begin
        pay_q.push_back(8'($urandom));
        inval_q.push_back($urandom_range(7) == 0);
      end
      run_pkt(d, l, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
